// File: rtl/gol_pkg.sv
// Shared types and defaults for the Game of Life generation sequencer.
// Holds the sequencer state encoding, the handshake phase encoding and default widths.
package gol_pkg;

   localparam int GOL_ADDR_W     = 12;
   localparam int GOL_GEN_W      = 16;
   // engine_reset length used both at job start and on the abort path
   localparam int GOL_RST_CYCLES = 2;

   typedef enum logic [2:0] {
      IDLE,
      ENG_RST,
      INIT_REQ,
      INIT_ACK,
      GEN_REQ,
      GEN_ACK,
      DONE
   } gol_state_t;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_WAIT,
      PH_REQ,
      PH_ACK
   } gol_phase_t;

endpackage

// File: rtl/gol_fourphase_req.sv
// One four-phase request/completed channel driving either io_start or io_initialize.
// Latency: request rises on the launch edge (or one cycle after completed is seen low); drops the cycle after completed=1.
// Backpressure: a launch while completed is still high parks in PH_WAIT until completed falls.
module gol_fourphase_req
   import gol_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic launch,
   input  logic launch_init,
   input  logic cancel,
   input  logic completed,
   output logic req_start,
   output logic req_init,
   output logic got_ack,
   output logic released
);

   gol_phase_t phase;
   logic       kind_init;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase     <= PH_IDLE;
         kind_init <= 1'b0;
         req_start <= 1'b0;
         req_init  <= 1'b0;
      end else if (cancel) begin
         phase     <= PH_IDLE;
         req_start <= 1'b0;
         req_init  <= 1'b0;
      end else if (launch) begin
         kind_init <= launch_init;
         // never raise a request on top of a stale completed level
         if (completed) begin
            phase <= PH_WAIT;
         end else begin
            phase     <= PH_REQ;
            req_start <= !launch_init;
            req_init  <= launch_init;
         end
      end else begin
         case (phase)
            PH_WAIT: if (!completed) begin
               phase     <= PH_REQ;
               req_start <= !kind_init;
               req_init  <= kind_init;
            end
            PH_REQ: if (completed) begin
               phase     <= PH_ACK;
               req_start <= 1'b0;
               req_init  <= 1'b0;
            end
            PH_ACK: if (!completed) phase <= PH_IDLE;
            default: ;
         endcase
      end
   end

   assign got_ack  = (phase == PH_REQ) && completed;
   assign released = (phase == PH_ACK) && !completed;

endmodule

// File: rtl/gol_generation_sequencer.sv
// Runs N Game of Life generations on the engine, ping-ponging buffers A/B; optional watchdog via GOL_SEQ_WATCHDOG_EN.
// Latency: accept at T, engine_reset T+1..T+RST_CYCLES, first request at T+RST_CYCLES+1; >=4 cycles per generation.
// Backpressure: cmd_ready only in IDLE; each engine phase waits on io_completed (bounded only with the watchdog).
module gol_generation_sequencer
   import gol_pkg::*;
#(
   parameter int ADDR_W         = GOL_ADDR_W,
   parameter int GEN_W          = GOL_GEN_W,
   parameter int RST_CYCLES     = GOL_RST_CYCLES,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_init,
   input  logic [GEN_W-1:0]  cmd_generations,
   input  logic [ADDR_W-1:0] cmd_base_a,
   input  logic [ADDR_W-1:0] cmd_base_b,
   input  logic              abort,
   output logic              io_start,
   output logic              io_initialize,
   output logic [ADDR_W-1:0] io_starting_address,
   output logic [ADDR_W-1:0] io_result_address,
   output logic              engine_reset,
   input  logic              io_completed,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic              timeout,
   output logic [GEN_W-1:0]  gen_count,
   output logic [ADDR_W-1:0] final_address
);

   localparam int RC_W = $clog2(RST_CYCLES + 1);

   gol_state_t        state;
   logic [RC_W-1:0]   rst_cnt;
   logic              abort_path;
   logic              init_q;
   logic [GEN_W-1:0]  gens_q;
   logic [ADDR_W-1:0] base_a_q;
   logic [ADDR_W-1:0] base_b_q;

   logic             got_ack, released, in_phase, abort_hit, wd_fire, cancel;
   logic             rst_last, gen_last, launch, launch_init, launch_gen, launch_odd, go_done;
   logic [GEN_W:0]   gen_next;

   assign in_phase  = (state == INIT_REQ) || (state == INIT_ACK) || (state == GEN_REQ) || (state == GEN_ACK);
   assign abort_hit = abort && (in_phase || state == ENG_RST) && !abort_path;
   assign cancel    = abort_hit || wd_fire;
   assign rst_last  = (state == ENG_RST) && (rst_cnt == '0);
   assign gen_next  = {1'b0, gen_count} + (GEN_W+1)'(1);
   assign gen_last  = (gen_next == {1'b0, gens_q});

   assign launch_init = !cancel && rst_last && !abort_path && init_q;
   assign launch_gen  = !cancel &&
                        ((rst_last && !abort_path && !init_q && gens_q != '0) ||
                         (state == INIT_ACK && released && gens_q != '0) ||
                         (state == GEN_ACK && released && !gen_last));
   assign launch      = launch_init || launch_gen;
   // parity of the generation about to be launched selects the buffer direction
   assign launch_odd  = (state == GEN_ACK) && gen_next[0];
   assign go_done     = !cancel &&
                        ((rst_last && (abort_path || (!init_q && gens_q == '0))) ||
                         (state == INIT_ACK && released && gens_q == '0) ||
                         (state == GEN_ACK && released && gen_last));

`ifdef GOL_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         wd_cnt <= '0;
      else if (!in_phase || got_ack || released || cancel)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + WD_W'(1);
   end

   assign wd_fire = in_phase && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
   assign wd_fire = 1'b0;
`endif

   gol_fourphase_req u_req (
      .clock       (clock),
      .reset       (reset),
      .launch      (launch),
      .launch_init (launch_init),
      .cancel      (cancel),
      .completed   (io_completed),
      .req_start   (io_start),
      .req_init    (io_initialize),
      .got_ack     (got_ack),
      .released    (released)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         cmd_ready           <= 1'b1;
         busy                <= 1'b0;
         done                <= 1'b0;
         aborted             <= 1'b0;
         timeout             <= 1'b0;
         engine_reset        <= 1'b0;
         gen_count           <= '0;
         final_address       <= '0;
         io_starting_address <= '0;
         io_result_address   <= '0;
         rst_cnt             <= '0;
         abort_path          <= 1'b0;
         init_q              <= 1'b0;
         gens_q              <= '0;
         base_a_q            <= '0;
         base_b_q            <= '0;
      end else begin
         done <= 1'b0;
         if (launch) begin
            io_starting_address <= (launch_init || !launch_odd) ? base_a_q : base_b_q;
            io_result_address   <= (!launch_init && !launch_odd) ? base_b_q : base_a_q;
         end
         if (cancel) begin
            state        <= ENG_RST;
            engine_reset <= 1'b1;
            rst_cnt      <= RC_W'(RST_CYCLES - 1);
            abort_path   <= 1'b1;
            if (abort_hit) aborted <= 1'b1;
            else           timeout <= 1'b1;
         end else begin
            case (state)
               IDLE: if (cmd_valid) begin
                  init_q       <= cmd_init;
                  gens_q       <= cmd_generations;
                  base_a_q     <= cmd_base_a;
                  base_b_q     <= cmd_base_b;
                  gen_count    <= '0;
                  aborted      <= 1'b0;
                  timeout      <= 1'b0;
                  busy         <= 1'b1;
                  cmd_ready    <= 1'b0;
                  abort_path   <= 1'b0;
                  engine_reset <= 1'b1;
                  rst_cnt      <= RC_W'(RST_CYCLES - 1);
                  state        <= ENG_RST;
               end
               ENG_RST: if (rst_cnt != '0) begin
                  rst_cnt <= rst_cnt - RC_W'(1);
               end else begin
                  engine_reset <= 1'b0;
                  state        <= launch_init ? INIT_REQ : GEN_REQ;
               end
               INIT_REQ: if (got_ack) state <= INIT_ACK;
               INIT_ACK: if (released) state <= GEN_REQ;
               GEN_REQ:  if (got_ack) state <= GEN_ACK;
               GEN_ACK:  if (released) begin
                  if (gen_count != gens_q) gen_count <= gen_count + GEN_W'(1);
                  state <= GEN_REQ;
               end
               DONE: begin
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
               end
               default: state <= IDLE;
            endcase
            // every route into DONE shares the same exit bookkeeping
            if (go_done) begin
               state         <= DONE;
               done          <= 1'b1;
               busy          <= 1'b0;
               final_address <= gens_q[0] ? base_b_q : base_a_q;
            end
         end
      end
   end

endmodule

// File: doc/gol_generation_sequencer.md
# gol_generation_sequencer

Hardware host for the Game of Life engine. It drives the engine's start, initialize, address and reset controls and watches its completed flag, so that N generations run with no HPS intervention per generation. Between generations it swaps the two board buffers in on-chip memory. It sits between the HPS PIO bank, which issues one command per job, and the engine control inputs those PIOs drove directly until now.

## Interface
Parameters:
- ADDR_W, 12: on-chip memory address width.
- GEN_W, 16: width of the generation count.
- RST_CYCLES, 2: cycles `engine_reset` is held high.
- TIMEOUT_CYCLES, 1048576: watchdog limit per engine phase.

Ports:
- clock, in, 1: the only clock.
- reset, in, 1: asynchronous, active-high.
- cmd_valid, in, 1: job request.
- cmd_ready, out, 1: high only in IDLE.
- cmd_init, in, 1: run one initialize phase before the generations.
- cmd_generations, in, GEN_W: number of generations to run.
- cmd_base_a, in, ADDR_W: buffer A base; holds the source board for generation 0.
- cmd_base_b, in, ADDR_W: buffer B base.
- abort, in, 1: cancel the job in flight.
- io_start, out, 1: engine start level.
- io_initialize, out, 1: engine initialize level.
- io_starting_address, out, ADDR_W: source buffer for the engine.
- io_result_address, out, ADDR_W: destination buffer for the engine.
- engine_reset, out, 1: active-high reset to the engine.
- io_completed, in, 1: engine completion level.
- busy, out, 1: a job is in flight.
- done, out, 1: one-cycle pulse at job end.
- aborted, out, 1: sticky; cleared at next accept.
- timeout, out, 1: sticky; cleared at next accept.
- gen_count, out, GEN_W: generations completed in the current job.
- final_address, out, ADDR_W: buffer holding the final board.

## Operation
- All outputs are registered.
- Reset values:
  - cmd_ready=1.
  - Every other output is 0, including the io_* outputs, the status flags and both counters.
- A job is accepted on `cmd_valid && cmd_ready`. On accept, the block:
  - latches the command fields;
  - clears gen_count, aborted and timeout;
  - sets busy=1.
- States:
  - IDLE.
  - ENG_RST: engine_reset=1 for RST_CYCLES cycles. Then INIT_REQ if cmd_init, otherwise GEN_REQ. If cmd_generations==0 and !cmd_init, go straight to DONE.
  - INIT_REQ: io_initialize=1. Wait for io_completed=1, then INIT_ACK.
  - INIT_ACK: io_initialize=0. Wait for io_completed=0. Then GEN_REQ, or DONE if cmd_generations==0.
  - GEN_REQ: io_start=1. Wait for io_completed=1, then GEN_ACK.
  - GEN_ACK: io_start=0. Wait for io_completed=0, then increment gen_count. If gen_count equals cmd_generations, go to DONE; otherwise go to GEN_REQ.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Control handshake is four-phase:
  - The request is held until completed rises.
  - completed must fall before the next request.
  - The request is never asserted while io_completed=1.
- Address ping-pong:
  - gen_count even: starting=A, result=B.
  - gen_count odd: starting=B, result=A.
  - The initialize phase uses starting=A, result=A.
  - Addresses are stable for the whole REQ/ACK pair.
- final_address is set in DONE:
  - A if cmd_generations is even, including 0.
  - B if cmd_generations is odd.
- Abort:
  - In any state other than IDLE or DONE, abort=1 drops io_start and io_initialize the next cycle.
  - It then applies RST_CYCLES of engine_reset and goes to DONE with aborted=1.
  - gen_count keeps the number of completed generations.
  - Abort in IDLE is ignored.
  - Abort and cmd_valid together in IDLE: the command is accepted.
- gen_count saturates at cmd_generations. It does not wrap, and the maximum count is 2^GEN_W−1.

## Timing
- Accept in cycle T: ENG_RST covers T+1..T+RST_CYCLES, and the first request rises at T+RST_CYCLES+1.
- Request to response:
  - completed=1 sampled in cycle C drops the request at C+1.
  - completed=0 sampled in cycle D advances the state at D+1.
- Minimum cost per generation with an ideal engine is 4 cycles.
- done is high exactly one cycle. cmd_ready rises the cycle after done.
- Reset asserted mid-job:
  - All outputs return to their reset values asynchronously.
  - The engine is not given engine_reset. Software must re-issue the job.

## Configuration
- GOL_SEQ_WATCHDOG_EN defined:
  - A per-phase counter clears on every REQ/ACK entry.
  - If it reaches TIMEOUT_CYCLES, the block takes the abort path with timeout=1 (aborted stays 0).
- GOL_SEQ_WATCHDOG_EN undefined:
  - No counter.
  - timeout is tied to 0.
  - The sequencer waits on io_completed indefinitely.

## Structure
- Package gol_pkg holds:
  - the state enum (IDLE, ENG_RST, INIT_REQ, INIT_ACK, GEN_REQ, GEN_ACK, DONE);
  - ADDR_W and GEN_W defaults;
  - the abort-path reset length.
- The natural sub-module is gol_fourphase_req: one request/ack four-phase channel, instantiated once and muxed between initialize and start.
- The sequencer is instantiated in GameOfLifeTop between the PIO exports and GameOfLifeWrapper.

## Test plan
- Engine model completes 3 cycles after each request; cmd_generations=3, A=0x000, B=0x400, cmd_init=0:
  - 3 start handshakes with addresses (0,0x400), (0x400,0), (0,0x400);
  - final_address=0x400, gen_count=3, one done pulse.
- cmd_init=1, cmd_generations=0: one initialize handshake, no start, final_address=A, done.
- Engine holds completed=1 for 5 cycles after a request drops: the next io_start does not rise until 1 cycle after completed falls.
- abort in the second GEN_REQ of a 10-generation job:
  - io_start=0 the next cycle;
  - engine_reset high 2 cycles;
  - aborted=1, gen_count=1, done pulses.
- With GOL_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=64, engine never completes: timeout=1 after 64 cycles in GEN_REQ, then engine_reset, done, cmd_ready=1.
- reset asserted mid-GEN_ACK: all outputs 0 and cmd_ready=1 immediately; a new job then runs normally.
